// File: rtl/prefix_sum_pipe_16b.sv
// Three-stage Kogge-Stone carry network and sum post-processing for a 16-bit
// parallel-prefix adder, with a valid/ready pipeline and synchronous flush.
module prefix_sum_pipe_16b (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [16:0] prop_i,
  input  logic [16:0] gen_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [15:0] sum_o,
  output logic        carry_o
);

  typedef struct packed {
    logic [16:0] g;
    logic [16:0] p;
  } gp_t;

  function automatic gp_t kogge_level(input gp_t x, input int d);
    gp_t y;
    y = x;
    for (int i = 16; i >= d; i--) begin
      y.g[i] = x.g[i] | (x.p[i] & x.g[i-d]);
      y.p[i] = x.p[i] & x.p[i-d];
    end
    return y;
  endfunction

  logic        v1, v2, v3;
  logic        adv1, adv2, adv3;
  gp_t         s1_gp, s2_gp;
  logic [15:0] s1_raw, s2_raw;
  gp_t         in_gp, l1_gp, l2_gp, l3_gp;
  logic        unused_bits;

  // Position 0 carries only the carry-in, so its propagate is forced to 0.
  assign in_gp = {gen_i, prop_i[16:1], 1'b0};
  assign l1_gp = kogge_level(kogge_level(in_gp, 1), 2);
  assign l2_gp = kogge_level(kogge_level(s1_gp, 4), 8);
  assign l3_gp = kogge_level(s2_gp, 16);

  assign unused_bits = ^{prop_i[0], l3_gp.p};

  assign adv3    = !v3 || ready_i;
  assign adv2    = !v2 || adv3;
  assign adv1    = !v1 || adv2;
  assign ready_o = adv1;
  assign valid_o = v3;

  // Flush only kills the valid bits; data registers may load harmlessly.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      v3      <= 1'b0;
      s1_gp   <= '0;
      s1_raw  <= '0;
      s2_gp   <= '0;
      s2_raw  <= '0;
      sum_o   <= '0;
      carry_o <= 1'b0;
    end else begin
      if (flush_i) begin
        v1 <= 1'b0;
        v2 <= 1'b0;
        v3 <= 1'b0;
      end else begin
        if (adv1) v1 <= valid_i;
        if (adv2) v2 <= v1;
        if (adv3) v3 <= v2;
      end
      if (adv1 && valid_i) begin
        s1_gp  <= l1_gp;
        s1_raw <= prop_i[16:1];
      end
      if (adv2 && v1) begin
        s2_gp  <= l2_gp;
        s2_raw <= s1_raw;
      end
      if (adv3 && v2) begin
        sum_o   <= s2_raw ^ l3_gp.g[15:0];
        carry_o <= l3_gp.g[16];
      end
    end
  end

endmodule

// File: tb/tb_prefix_sum_pipe_16b.sv
// Directed bench for prefix_sum_pipe_16b: a scoreboard queue holds a+b+cin for
// every accepted beat and a negedge monitor compares each delivered beat.
module tb_prefix_sum_pipe_16b;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        valid_i;
  logic        ready_o;
  logic [16:0] prop_i;
  logic [16:0] gen_i;
  logic        valid_o;
  logic        ready_i;
  logic [15:0] sum_o;
  logic        carry_o;

  int          errors = 0;
  int          checks = 0;
  int          cycle = 0;
  logic [16:0] exp_q[$];
  int          pop_cycles[$];
  logic [15:0] held_sum;

  prefix_sum_pipe_16b dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .prop_i  (prop_i),
    .gen_i   (gen_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .sum_o   (sum_o),
    .carry_o (carry_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Every output transfer is matched against the oldest accepted beat.
  always @(negedge clk_i) begin
    if (valid_o === 1'b1 && ready_i === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("spurious_beat", 32'd1, 32'd0);
      end else begin
        logic [16:0] exp;
        exp = exp_q.pop_front();
        checkOutput("sum", {16'd0, sum_o}, {16'd0, exp[15:0]});
        checkOutput("carry", {31'd0, carry_o}, {31'd0, exp[16]});
        pop_cycles.push_back(cycle);
      end
    end
  end

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic cin);
    logic accepted;
    logic [16:0] total;
    accepted = 1'b0;
    total    = {1'b0, a} + {1'b0, b} + {16'd0, cin};
    prop_i   = {a ^ b, 1'($urandom)};
    gen_i    = {a & b, cin};
    valid_i  = 1'b1;
    for (int t = 0; t < 30 && !accepted; t++) begin
      @(negedge clk_i);
      if (ready_o) begin
        exp_q.push_back(total);
        accepted = 1'b1;
      end
      @(posedge clk_i);
      #1;
    end
    valid_i = 1'b0;
    if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  // Called right after the capture edge of a lone beat.
  task automatic checkLatency(input string tag);
    checkOutput({tag, "_lat0"}, {31'd0, valid_o}, 32'd0);
    @(posedge clk_i); #1;
    checkOutput({tag, "_lat1"}, {31'd0, valid_o}, 32'd0);
    @(posedge clk_i); #1;
    checkOutput({tag, "_lat2"}, {31'd0, valid_o}, 32'd1);
    @(posedge clk_i); #1;
    checkOutput({tag, "_lat3"}, {31'd0, valid_o}, 32'd0);
  endtask

  task automatic waitDrain(input string tag);
    for (int t = 0; t < 40 && exp_q.size() != 0; t++) begin
      @(posedge clk_i); #1;
    end
    checkOutput({tag, "_drain"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_ni  = 1'b0;
    flush_i = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    prop_i  = '0;
    gen_i   = '0;
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("rst_valid", {31'd0, valid_o}, 32'd0);
    checkOutput("rst_sum", {16'd0, sum_o}, 32'd0);
    checkOutput("rst_carry", {31'd0, carry_o}, 32'd0);
    checkOutput("rst_ready", {31'd0, ready_o}, 32'd1);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    $display("[TB] single beat");
    applyStimulus(16'h1234, 16'h4321, 1'b0);
    checkLatency("single");
    waitDrain("single");

    $display("[TB] full ripple");
    applyStimulus(16'hFFFF, 16'h0001, 1'b0);
    applyStimulus(16'hFFFF, 16'h0000, 1'b1);
    waitDrain("ripple");

    $display("[TB] back-to-back stream");
    pop_cycles.delete();
    for (int k = 0; k < 10; k++)
      applyStimulus(16'($urandom), 16'($urandom), 1'($urandom));
    waitDrain("stream");
    checkOutput("stream_count", pop_cycles.size(), 32'd10);
    if (pop_cycles.size() == 10)
      checkOutput("stream_span", pop_cycles[9] - pop_cycles[0], 32'd9);

    $display("[TB] back-pressure");
    pop_cycles.delete();
    ready_i = 1'b0;
    for (int k = 0; k < 3; k++)
      applyStimulus(16'($urandom), 16'($urandom), 1'($urandom));
    checkOutput("bp_full_ready", {31'd0, ready_o}, 32'd0);
    checkOutput("bp_full_valid", {31'd0, valid_o}, 32'd1);
    held_sum = sum_o;
    prop_i   = {16'hA5A5 ^ 16'h0F0F, 1'b0};
    gen_i    = {16'hA5A5 & 16'h0F0F, 1'b0};
    valid_i  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk_i); #1;
      checkOutput("bp_stall_ready", {31'd0, ready_o}, 32'd0);
      checkOutput("bp_stall_sum", {16'd0, sum_o}, {16'd0, held_sum});
    end
    ready_i = 1'b1;
    #1;
    checkOutput("bp_release_ready", {31'd0, ready_o}, 32'd1);
    applyStimulus(16'hA5A5, 16'h0F0F, 1'b0);
    applyStimulus(16'($urandom), 16'($urandom), 1'($urandom));
    waitDrain("bp");
    checkOutput("bp_count", pop_cycles.size(), 32'd5);

    $display("[TB] flush");
    for (int k = 0; k < 3; k++)
      applyStimulus(16'($urandom), 16'($urandom), 1'($urandom));
    prop_i  = {16'h7777 ^ 16'h1111, 1'b0};
    gen_i   = {16'h7777 & 16'h1111, 1'b0};
    valid_i = 1'b1;
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    valid_i = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 4; k++) begin
      checkOutput("flush_empty", {31'd0, valid_o}, 32'd0);
      @(posedge clk_i); #1;
    end
    applyStimulus(16'h0800, 16'h0800, 1'b1);
    checkLatency("post_flush");
    waitDrain("post_flush");

    $display("[TB] async reset with full pipe");
    ready_i = 1'b0;
    for (int k = 0; k < 3; k++) applyStimulus(16'hF001, 16'h1001, 1'b0);
    checkOutput("pre_rst_valid", {31'd0, valid_o}, 32'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    checkOutput("arst_valid", {31'd0, valid_o}, 32'd0);
    checkOutput("arst_sum", {16'd0, sum_o}, 32'd0);
    checkOutput("arst_carry", {31'd0, carry_o}, 32'd0);
    exp_q.delete();
    @(posedge clk_i); #3;
    rst_ni = 1'b1;
    #1;
    checkOutput("arst_ready", {31'd0, ready_o}, 32'd1);
    ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk_i); #1;
      checkOutput("arst_quiet", {31'd0, valid_o}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
